sensor_membuf_drain: RTL and testbench

Memory-side drain controller for one sensor channel, clocked by the memory interface clock. It counts buffer pages reported complete by the sensor channel memory buffer and requests write access from the memory controller. When granted, it issues the buffer read strobes for one page, then advances the buffer read page. It sits directly downstream of the sensor buffer, driving its `rpage_set`, `rpage_next` and `buf_rd` inputs and consuming its `page_written` pulse.

---
 rtl/sensor_membuf_drain.sv | 125 ++++++++++++
 tb/tb_sensor_membuf_drain.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_membuf_drain.sv
// Drain controller: counts completed sensor buffer pages and reads one page per memory grant.
// Optional `SENSOR_DRAIN_STATUS_EN builds the pages_done transfer counter.
module sensor_membuf_drain #(
    parameter int PAGE_WORDS  = 128,
    parameter int NEED_THRESH = 2
) (
    input  logic        mclk,
    input  logic        mrst,
    input  logic        frame_start,
    input  logic        page_written,
    input  logic        xfer_start,
    input  logic        xfer_rd,
    output logic        rpage_set,
    output logic        rpage_next,
    output logic        buf_rd,
    output logic        want_wr,
    output logic        need_wr,
    output logic        xfer_done,
    output logic        overflow,
    output logic [15:0] pages_done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_NEXT = 2'd3;

    localparam logic [8:0] LAST_WORD = 9'(PAGE_WORDS);
    localparam logic [2:0] THRESH    = 3'(NEED_THRESH);
    localparam logic [2:0] MAX_PEND  = 3'd4;

    logic [1:0] state_q, state_d;
    logic [2:0] pending_q, pending_d;
    logic [8:0] wcnt_q, wcnt_d;
    logic       overflow_q, overflow_d;
    logic       rpage_set_q, rpage_set_d;
    logic       init_q, init_d;

    // frame_start wins over everything, including a word or page completion in flight
    always_comb begin
        buf_rd     = (state_q == S_XFER) && xfer_rd && !frame_start;
        rpage_next = (state_q == S_NEXT) && !frame_start;
        xfer_done  = rpage_next;
        want_wr    = (pending_q != 3'd0) && ((state_q == S_IDLE) || (state_q == S_REQ));
        need_wr    = want_wr && (pending_q >= THRESH);
        rpage_set  = rpage_set_q;
        overflow   = overflow_q;
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        wcnt_d      = wcnt_q;
        overflow_d  = overflow_q;
        rpage_set_d = init_q;
        init_d      = 1'b0;
        if (frame_start) begin
            state_d     = S_IDLE;
            pending_d   = 3'd0;
            wcnt_d      = 9'd0;
            overflow_d  = 1'b0;
            rpage_set_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (pending_q != 3'd0) state_d = S_REQ;
                S_REQ:  if (xfer_start) state_d = S_XFER;
                S_XFER: begin
                    if (buf_rd) begin
                        wcnt_d = wcnt_q + 9'd1;
                        if (wcnt_d == LAST_WORD) state_d = S_NEXT;
                    end
                end
                default: begin
                    wcnt_d  = 9'd0;
                    state_d = S_IDLE;
                end
            endcase
            // simultaneous arrival and completion cancel out
            if (page_written && !rpage_next) begin
                if (pending_q == MAX_PEND) overflow_d = 1'b1;
                else pending_d = pending_q + 3'd1;
            end else if (!page_written && rpage_next) begin
                pending_d = pending_q - 3'd1;
            end
        end
    end

    // init_q makes rpage_set pulse once right after reset releases
    always_ff @(posedge mclk) begin
        if (mrst) begin
            state_q     <= S_IDLE;
            pending_q   <= 3'd0;
            wcnt_q      <= 9'd0;
            overflow_q  <= 1'b0;
            rpage_set_q <= 1'b0;
            init_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            wcnt_q      <= wcnt_d;
            overflow_q  <= overflow_d;
            rpage_set_q <= rpage_set_d;
            init_q      <= init_d;
        end
    end

`ifdef SENSOR_DRAIN_STATUS_EN
    logic [15:0] pages_done_q, pages_done_d;

    always_comb begin
        pages_done_d = pages_done_q;
        if (frame_start) pages_done_d = 16'd0;
        else if (xfer_done) pages_done_d = pages_done_q + 16'd1;
    end

    always_ff @(posedge mclk) begin
        if (mrst) pages_done_q <= 16'd0;
        else pages_done_q <= pages_done_d;
    end

    assign pages_done = pages_done_q;
`else
    assign pages_done = 16'd0;
`endif

endmodule

// File: tb/tb_sensor_membuf_drain.sv
// Scoreboard bench for sensor_membuf_drain: expected words per page are queued at grant
// and compared with the buf_rd count the monitor records at each xfer_done.
module tb_sensor_membuf_drain;
    localparam int PW = 128;
    localparam int NT = 2;
`ifdef SENSOR_DRAIN_STATUS_EN
    localparam int STAT_EN = 1;
`else
    localparam int STAT_EN = 0;
`endif

    logic        mclk = 1'b0;
    logic        mrst, frame_start, page_written, xfer_start, xfer_rd;
    logic        rpage_set, rpage_next, buf_rd, want_wr, need_wr, xfer_done, overflow;
    logic [15:0] pages_done;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int obs_q[$];
    int rd_cnt = 0;
    int done_cnt = 0;
    int rpset_cnt = 0;

    sensor_membuf_drain #(.PAGE_WORDS(PW), .NEED_THRESH(NT)) dut (
        .mclk(mclk), .mrst(mrst), .frame_start(frame_start), .page_written(page_written),
        .xfer_start(xfer_start), .xfer_rd(xfer_rd), .rpage_set(rpage_set),
        .rpage_next(rpage_next), .buf_rd(buf_rd), .want_wr(want_wr), .need_wr(need_wr),
        .xfer_done(xfer_done), .overflow(overflow), .pages_done(pages_done)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) begin
        if (rpage_set) rpset_cnt++;
        if (xfer_done) done_cnt++;
        if (mrst || frame_start) rd_cnt = 0;
        else begin
            if (buf_rd) rd_cnt++;
            if (xfer_done) begin
                obs_q.push_back(rd_cnt);
                rd_cnt = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // pulse a page (optional), grant, stream words until xfer_done, then leave NEXT
    task automatic do_page(input bit pulse, input bit pw_at_next, output bit ok);
        ok = 1'b0;
        if (pulse) begin
            page_written = 1'b1; tick(); page_written = 1'b0;
        end
        tick();
        xfer_start = 1'b1; tick(); xfer_start = 1'b0;
        exp_q.push_back(PW);
        xfer_rd = 1'b1;
        for (int i = 0; i < 4 * PW; i++) begin
            if (xfer_done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        page_written = pw_at_next;
        xfer_rd = 1'b0;
        tick();
        page_written = 1'b0;
    endtask

    task automatic test_reset();
        mrst = 1'b1; frame_start = 1'b0; page_written = 1'b0; xfer_start = 1'b0; xfer_rd = 1'b0;
        repeat (3) tick();
        tests++;
        if ({rpage_set, rpage_next, buf_rd, want_wr, need_wr, xfer_done, overflow, pages_done} !== 23'd0) begin
            fails++;
            $display("FAIL reset_outputs got %b want all zero",
                     {rpage_set, rpage_next, buf_rd, want_wr, need_wr, xfer_done, overflow, pages_done});
        end
        rpset_cnt = 0;
        mrst = 1'b0;
        repeat (4) tick();
        tests++;
        if (rpset_cnt !== 1) begin
            fails++; $display("FAIL reset_rpage_set pulses got %0d want 1", rpset_cnt);
        end
    endtask

    task automatic test_single_page();
        int cyc;
        int o, e;
        page_written = 1'b1; tick(); page_written = 1'b0;
        tests++;
        if ({want_wr, need_wr} !== 2'b10 || dut.pending_q !== 3'd1) begin
            fails++; $display("FAIL single_want got want=%b need=%b pend=%0d want 1 0 1", want_wr, need_wr, dut.pending_q);
        end
        tick();
        tests++;
        if (dut.state_q !== 2'd1) begin
            fails++; $display("FAIL single_req state got %0d want 1", dut.state_q);
        end
        xfer_start = 1'b1; tick(); xfer_start = 1'b0;
        exp_q.push_back(PW);
        xfer_rd = 1'b1;
        cyc = 0;
        while (!xfer_done && cyc < 4 * PW) begin
            tick(); cyc++;
        end
        tests++;
        if (cyc !== PW || rpage_next !== 1'b1) begin
            fails++; $display("FAIL single_latency got cyc=%0d next=%b want %0d 1", cyc, rpage_next, PW);
        end
        xfer_rd = 1'b0;
        tick();
        tests++;
        if ({xfer_done, rpage_next, want_wr} !== 3'b000 || dut.pending_q !== 3'd0 || dut.state_q !== 2'd0) begin
            fails++; $display("FAIL single_after got done=%b next=%b want=%b pend=%0d st=%0d want 0 0 0 0 0",
                              xfer_done, rpage_next, want_wr, dut.pending_q, dut.state_q);
        end
        o = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
        e = exp_q.pop_front();
        tests++;
        if (o !== e) begin
            fails++; $display("FAIL single_words got %0d want %0d", o, e);
        end
    endtask

    task automatic test_backlog();
        bit ok;
        int o, e;
        for (int i = 1; i <= 5; i++) begin
            page_written = 1'b1; tick(); page_written = 1'b0;
            tests++;
            if (need_wr !== (i >= 2) || overflow !== (i == 5) || dut.pending_q !== 3'((i > 4) ? 4 : i)) begin
                fails++; $display("FAIL backlog_%0d got need=%b ovf=%b pend=%0d", i, need_wr, overflow, dut.pending_q);
            end
        end
        for (int k = 0; k < 2; k++) begin
            do_page(1'b0, 1'b0, ok);
            tests++;
            if (!ok) begin fails++; $display("FAIL backlog_drain_timeout page %0d", k); end
        end
        tests++;
        if (dut.pending_q !== 3'd2) begin
            fails++; $display("FAIL backlog_drained pend got %0d want 2", dut.pending_q);
        end
        do_page(1'b0, 1'b1, ok);
        tests++;
        if (!ok || dut.pending_q !== 3'd2 || want_wr !== 1'b1 || overflow !== 1'b1) begin
            fails++; $display("FAIL simultaneous got ok=%b pend=%0d want_wr=%b ovf=%b want 1 2 1 1",
                              ok, dut.pending_q, want_wr, overflow);
        end
        for (int k = 0; k < 3; k++) begin
            o = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
            e = exp_q.pop_front();
            tests++;
            if (o !== e) begin fails++; $display("FAIL backlog_words page %0d got %0d want %0d", k, o, e); end
        end
    endtask

    task automatic test_stall();
        int cyc;
        int early;
        int o, e;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        page_written = 1'b1; tick(); page_written = 1'b0;
        tick();
        xfer_start = 1'b1; tick(); xfer_start = 1'b0;
        exp_q.push_back(PW);
        cyc = 0; early = 0;
        while (!xfer_done && cyc < 8 * PW) begin
            xfer_rd = (cyc % 2 == 0);
            tick(); cyc++;
            if (rpage_next && rd_cnt != PW) early++;
        end
        tests++;
        if (cyc !== 2 * PW - 1 || early !== 0) begin
            fails++; $display("FAIL stall_timing got cyc=%0d early=%0d want %0d 0", cyc, early, 2 * PW - 1);
        end
        xfer_rd = 1'b0;
        tick();
        o = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
        e = exp_q.pop_front();
        tests++;
        if (o !== e) begin fails++; $display("FAIL stall_words got %0d want %0d", o, e); end
    endtask

    task automatic test_abort();
        bit ok;
        int d0;
        int o, e;
        page_written = 1'b1; repeat (5) tick(); page_written = 1'b0;
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL abort_setup ovf got %b want 1", overflow); end
        tick();
        xfer_start = 1'b1; tick(); xfer_start = 1'b0;
        xfer_rd = 1'b1;
        repeat (50) tick();
        tests++;
        if (rd_cnt !== 50) begin fails++; $display("FAIL abort_words_before got %0d want 50", rd_cnt); end
        d0 = done_cnt;
        frame_start = 1'b1; xfer_rd = 1'b0; tick(); frame_start = 1'b0;
        tests++;
        if ({rpage_set, xfer_done, want_wr, overflow} !== 4'b1000 || dut.pending_q !== 3'd0 || dut.state_q !== 2'd0) begin
            fails++; $display("FAIL abort_state got set=%b done=%b want=%b ovf=%b pend=%0d st=%0d want 1 0 0 0 0 0",
                              rpage_set, xfer_done, want_wr, overflow, dut.pending_q, dut.state_q);
        end
        repeat (3) tick();
        tests++;
        if (done_cnt !== d0) begin fails++; $display("FAIL abort_no_done got %0d want %0d", done_cnt, d0); end
        do_page(1'b1, 1'b0, ok);
        o = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
        e = exp_q.pop_front();
        tests++;
        if (!ok || o !== e) begin fails++; $display("FAIL abort_next_page got ok=%b words=%0d want 1 %0d", ok, o, e); end
    endtask

    task automatic test_status();
        bit ok;
        int o, e;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        tests++;
        if (pages_done !== 16'd0) begin fails++; $display("FAIL status_clear got %0d want 0", pages_done); end
        for (int k = 0; k < 3; k++) do_page(1'b1, 1'b0, ok);
        tests++;
        if (pages_done !== 16'(3 * STAT_EN)) begin
            fails++; $display("FAIL status_count got %0d want %0d", pages_done, 3 * STAT_EN);
        end
        for (int k = 0; k < 3; k++) begin
            o = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
            e = exp_q.pop_front();
            tests++;
            if (o !== e) begin fails++; $display("FAIL status_words page %0d got %0d want %0d", k, o, e); end
        end
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        tests++;
        if (pages_done !== 16'd0) begin fails++; $display("FAIL status_frame_clear got %0d want 0", pages_done); end
    endtask

    initial begin
        test_reset();
        test_single_page();
        test_backlog();
        test_stall();
        test_abort();
        test_status();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
